gold_code_gen: RTL and testbench

Parametrised Gold-code chip generator: two Fibonacci LFSRs of configurable length and feedback taps, XOR-combined into one chip per enabled clock. Supports seed load, an epoch counter with automatic re-seed at sequence wrap, and, when configured, GPS-style phase-select taps on the second register. Sits in the spreading-code path ahead of the correlator and modulator. Generalises the fixed-length delay-line generators to any register length and tap polynomial.

---
 rtl/gold_code_gen_pkg.sv | 18 +
 rtl/gold_code_gen_if.sv | 35 +++
 rtl/gold_code_gen_lfsr_fib.sv | 21 ++
 rtl/gold_code_gen.sv | 104 ++++++++++
 tb/tb_gold_code_gen.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/gold_code_gen_pkg.sv
// Shared constants for the Gold-code generator: GPS C/A defaults, seed type and all-ones seed.
package gold_pkg;

  localparam int          GOLD_MAX_LEN = 32;
  localparam int          GPS_LEN      = 10;
  localparam logic [31:0] GPS_TAPS_A   = 32'h0000_0204;
  localparam logic [31:0] GPS_TAPS_B   = 32'h0000_03A6;
  localparam int          GPS_SEQ_LEN  = 1023;

  // Seeds are carried at the widest supported length; users slice [LEN-1:0].
  typedef logic [GOLD_MAX_LEN-1:0] seed_t;
  localparam seed_t SEED_ONES = '1;

  function automatic int unsigned phase_clamp(input int unsigned sel, input int unsigned len);
    return (sel >= len) ? len - 1 : sel;
  endfunction

endpackage

// File: rtl/gold_code_gen_if.sv
// Chip-generator control/status bundle; Phase_Sel_0/1 exist only with GOLD_PHASE_TAP_EN.
interface gold_code_gen_if #(
  parameter int LEN = 10,
  parameter int CW  = 10
);
`ifdef GOLD_PHASE_TAP_EN
  localparam int PSW = $clog2(LEN);
  logic [PSW-1:0] Phase_Sel_0;
  logic [PSW-1:0] Phase_Sel_1;
`endif
  logic           Enable;
  logic           Load_En;
  logic [LEN-1:0] Seed_A;
  logic [LEN-1:0] Seed_B;
  logic           Chip;
  logic [CW-1:0]  Chip_Count;
  logic           Epoch;
  logic           Seed_Err;

  modport master (
`ifdef GOLD_PHASE_TAP_EN
    output Phase_Sel_0, Phase_Sel_1,
`endif
    output Enable, Load_En, Seed_A, Seed_B,
    input  Chip, Chip_Count, Epoch, Seed_Err
  );

  modport slave (
`ifdef GOLD_PHASE_TAP_EN
    input  Phase_Sel_0, Phase_Sel_1,
`endif
    input  Enable, Load_En, Seed_A, Seed_B,
    output Chip, Chip_Count, Epoch, Seed_Err
  );
endinterface

// File: rtl/gold_code_gen_lfsr_fib.sv
// Fibonacci LFSR: stage 0 is the input, stage i shifts to i+1, feedback is the parity of tapped stages.
module lfsr_fib #(
  parameter int             LEN  = 10,
  parameter logic [LEN-1:0] TAPS = {1'b1, {(LEN-1){1'b0}}}
) (
  input  logic           Clock,
  input  logic           Load,
  input  logic           Shift,
  input  logic [LEN-1:0] Seed,
  output logic [LEN-1:0] State
);

  always_ff @(posedge Clock) begin
    if (Load) begin
      State <= Seed;
    end else if (Shift) begin
      State <= {State[LEN-2:0], ^(State & TAPS)};
    end
  end

endmodule

// File: rtl/gold_code_gen.sv
// Gold-code chip generator: two LFSRs XOR-combined, epoch counter with re-seed at wrap.
// Optional GPS-style phase-select taps on register B when GOLD_PHASE_TAP_EN is defined.
module gold_code_gen
  import gold_pkg::*;
#(
  parameter int             LEN     = GPS_LEN,
  parameter logic [LEN-1:0] TAPS_A  = LEN'(GPS_TAPS_A),
  parameter logic [LEN-1:0] TAPS_B  = LEN'(GPS_TAPS_B),
  parameter int             SEQ_LEN = GPS_SEQ_LEN,
  parameter int             CW      = $clog2(SEQ_LEN)
) (
  input logic           Clock,
  input logic           Reset,
  gold_code_gen_if.slave bus
);

  localparam logic [LEN-1:0] ONES = SEED_ONES[LEN-1:0];
  localparam logic [CW-1:0]  LAST = CW'(SEQ_LEN - 1);

  logic [LEN-1:0] state_a, state_b;
  logic [LEN-1:0] held_a, held_b;
  logic [LEN-1:0] seed_a, seed_b;
  logic [CW-1:0]  count;
  logic           epoch, seed_err;
  logic           load_ok, wrap, reg_load, reg_shift;

  // Reset, accepted load and wrap all go through the register load path;
  // only the seed source differs.
  always_comb begin
    load_ok   = bus.Load_En && (|bus.Seed_A) && (|bus.Seed_B);
    wrap      = bus.Enable && !bus.Load_En && (count == LAST);
    reg_load  = Reset || load_ok || wrap;
    reg_shift = bus.Enable && !bus.Load_En;
    seed_a    = held_a;
    seed_b    = held_b;
    if (Reset) begin
      seed_a = ONES;
      seed_b = ONES;
    end else if (load_ok) begin
      seed_a = bus.Seed_A;
      seed_b = bus.Seed_B;
    end
  end

  lfsr_fib #(.LEN(LEN), .TAPS(TAPS_A)) u_lfsr_a (
    .Clock (Clock),
    .Load  (reg_load),
    .Shift (reg_shift),
    .Seed  (seed_a),
    .State (state_a)
  );

  lfsr_fib #(.LEN(LEN), .TAPS(TAPS_B)) u_lfsr_b (
    .Clock (Clock),
    .Load  (reg_load),
    .Shift (reg_shift),
    .Seed  (seed_b),
    .State (state_b)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      held_a   <= ONES;
      held_b   <= ONES;
      count    <= '0;
      epoch    <= 1'b0;
      seed_err <= 1'b0;
    end else begin
      epoch    <= 1'b0;
      seed_err <= 1'b0;
      if (bus.Load_En) begin
        if (load_ok) begin
          held_a <= bus.Seed_A;
          held_b <= bus.Seed_B;
          count  <= '0;
        end else begin
          seed_err <= 1'b1;
        end
      end else if (bus.Enable) begin
        if (wrap) begin
          count <= '0;
          epoch <= 1'b1;
        end else begin
          count <= count + CW'(1);
        end
      end
    end
  end

`ifdef GOLD_PHASE_TAP_EN
  localparam int PSW = $clog2(LEN);
  logic [PSW-1:0] sel0, sel1;
  assign sel0     = PSW'(phase_clamp(32'(bus.Phase_Sel_0), LEN));
  assign sel1     = PSW'(phase_clamp(32'(bus.Phase_Sel_1), LEN));
  assign bus.Chip = state_a[LEN-1] ^ state_b[sel0] ^ state_b[sel1];
`else
  assign bus.Chip = state_a[LEN-1] ^ state_b[LEN-1];
`endif

  assign bus.Chip_Count = count;
  assign bus.Epoch      = epoch;
  assign bus.Seed_Err   = seed_err;

endmodule

// File: tb/tb_gold_code_gen.sv
// Directed bench for gold_code_gen: GPS defaults plus two LEN=5 instances (full and short epoch).
module tb_gold_code_gen;

  typedef struct {
    logic [31:0] a, b, ha, hb;
    int unsigned cnt;
    logic        ep;
  } mdl_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned psel0       = 1;
  int unsigned psel1       = 5;
  int unsigned ep_seen;
  logic [9:0]  first10;
  logic [31:0] chip_hold;
  mdl_t md, m5, m7;

  gold_code_gen_if #(.LEN(10), .CW(10)) bus  ();
  gold_code_gen_if #(.LEN(5),  .CW(5))  bus5 ();
  gold_code_gen_if #(.LEN(5),  .CW(3))  bus7 ();

  gold_code_gen dut (.Clock(clk), .Reset(rst), .bus(bus));

  gold_code_gen #(.LEN(5), .TAPS_A(5'h12), .TAPS_B(5'h1E), .SEQ_LEN(31), .CW(5)) dut5 (
    .Clock(clk), .Reset(rst), .bus(bus5));

  gold_code_gen #(.LEN(5), .TAPS_A(5'h12), .TAPS_B(5'h1E), .SEQ_LEN(7), .CW(3)) dut7 (
    .Clock(clk), .Reset(rst), .bus(bus7));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] lstep(input logic [31:0] s, input logic [31:0] taps, input int unsigned len);
    logic [31:0] mask;
    mask = (len >= 32) ? '1 : ((32'h1 << len) - 32'h1);
    return ((s << 1) | 32'(^(s & taps))) & mask;
  endfunction

  function automatic mdl_t mreset(input int unsigned len);
    mdl_t m;
    m.a = (32'h1 << len) - 32'h1;
    m.b = m.a; m.ha = m.a; m.hb = m.a;
    m.cnt = 0; m.ep = 1'b0;
    return m;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input int unsigned len, input logic [31:0] ta,
                                 input logic [31:0] tb, input int unsigned seq);
    mdl_t r = m;
    if (m.cnt == seq - 1) begin
      r.a = m.ha; r.b = m.hb; r.cnt = 0; r.ep = 1'b1;
    end else begin
      r.a = lstep(m.a, ta, len); r.b = lstep(m.b, tb, len); r.cnt = m.cnt + 1; r.ep = 1'b0;
    end
    return r;
  endfunction

  function automatic mdl_t mload(input mdl_t m, input logic [31:0] sa, input logic [31:0] sb);
    mdl_t r = m;
    r.a = sa; r.b = sb; r.ha = sa; r.hb = sb; r.cnt = 0; r.ep = 1'b0;
    return r;
  endfunction

  function automatic logic mchip(input logic [31:0] a, input logic [31:0] b, input int unsigned len);
`ifdef GOLD_PHASE_TAP_EN
    int unsigned s0, s1;
    s0 = (psel0 >= len) ? len - 1 : psel0;
    s1 = (psel1 >= len) ? len - 1 : psel1;
    return a[len-1] ^ b[s0] ^ b[s1];
`else
    return a[len-1] ^ b[len-1];
`endif
  endfunction

  task automatic run_def(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      bus.Enable = 1'b1;
      tick();
      md = mstep(md, 10, 32'h204, 32'h3A6, 1023);
      chk("chip", 32'(bus.Chip), 32'(mchip(md.a, md.b, 10)));
      chk("count", 32'(bus.Chip_Count), md.cnt);
      chk("epoch", 32'(bus.Epoch), 32'(md.ep));
      chk("seed_err_idle", 32'(bus.Seed_Err), 32'h0);
      if (bus.Epoch) ep_seen++;
    end
    bus.Enable = 1'b0;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_a"}, 32'(dut.u_lfsr_a.State), md.a);
    chk({tag, "_b"}, 32'(dut.u_lfsr_b.State), md.b);
  endtask

  initial begin
`ifdef GOLD_PHASE_TAP_EN
    first10 = 10'b1100100000;
    bus.Phase_Sel_0 = 4'(psel0);  bus.Phase_Sel_1 = 4'(psel1);
    bus5.Phase_Sel_0 = 3'(psel0); bus5.Phase_Sel_1 = 3'(psel1);
    bus7.Phase_Sel_0 = 3'(psel0); bus7.Phase_Sel_1 = 3'(psel1);
`else
    first10 = 10'b0000000000;
`endif
    {bus.Enable, bus.Load_En, bus.Seed_A, bus.Seed_B}     = '0;
    {bus5.Enable, bus5.Load_En, bus5.Seed_A, bus5.Seed_B} = '0;
    {bus7.Enable, bus7.Load_En, bus7.Seed_A, bus7.Seed_B} = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    md = mreset(10); m5 = mreset(5); m7 = mreset(5);

    chk("rst_count", 32'(bus.Chip_Count), 32'h0);
    chk("rst_epoch", 32'(bus.Epoch), 32'h0);
    chk("rst_err", 32'(bus.Seed_Err), 32'h0);
    chk_state("rst_state");
    chk("rst_state_hand", 32'(dut.u_lfsr_a.State), 32'h3FF);

    // Enable low: everything holds at the reset state.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_chip", 32'(bus.Chip), 32'(first10[9]));
      chk("idle_count", 32'(bus.Chip_Count), 32'h0);
    end

    // First 10 chips of the epoch against the hand-computed vector.
    ep_seen = 0;
    chk("first_chip0", 32'(bus.Chip), 32'(first10[9]));
    for (int k = 1; k < 10; k++) begin
      run_def(1);
      chk("first_chip", 32'(bus.Chip), 32'(first10[9-k]));
    end

    // Finish the epoch: exactly one wrap, then the same 10 chips again.
    run_def(1023 - 9);
    chk("epoch_once", ep_seen, 32'd1);
    chk("wrap_count", 32'(bus.Chip_Count), 32'h0);
    chk("second_chip0", 32'(bus.Chip), 32'(first10[9]));
    for (int k = 1; k < 10; k++) begin
      run_def(1);
      chk("second_chip", 32'(bus.Chip), 32'(first10[9-k]));
    end

    // Rejected load: zero seed A, state frozen, error pulse.
    chip_hold = 32'(bus.Chip);
    bus.Load_En = 1'b1; bus.Seed_A = 10'h000; bus.Seed_B = 10'h3FF; bus.Enable = 1'b1;
    tick();
    bus.Load_En = 1'b0; bus.Enable = 1'b0;
    chk("rej_err", 32'(bus.Seed_Err), 32'h1);
    chk("rej_chip", 32'(bus.Chip), chip_hold);
    chk("rej_count", 32'(bus.Chip_Count), 32'd9);
    chk("rej_epoch", 32'(bus.Epoch), 32'h0);
    chk_state("rej_state");
    run_def(3);

    // Load on the wrap cycle: load wins, no epoch.
    run_def(1022 - md.cnt);
    chk("pre_wrap_count", 32'(bus.Chip_Count), 32'd1022);
    bus.Load_En = 1'b1; bus.Seed_A = 10'h155; bus.Seed_B = 10'h0F0; bus.Enable = 1'b1;
    tick();
    bus.Load_En = 1'b0; bus.Enable = 1'b0;
    md = mload(md, 32'h155, 32'h0F0);
    chk("wload_count", 32'(bus.Chip_Count), 32'h0);
    chk("wload_epoch", 32'(bus.Epoch), 32'h0);
    chk("wload_a_hand", 32'(dut.u_lfsr_a.State), 32'h155);
    chk("wload_b_hand", 32'(dut.u_lfsr_b.State), 32'h0F0);
    chk("wload_chip", 32'(bus.Chip), 32'(mchip(md.a, md.b, 10)));

    // Mid-epoch reset restarts from all ones.
    run_def(500);
    chk("pre_rst_count", 32'(bus.Chip_Count), 32'd500);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    md = mreset(10); m5 = mreset(5); m7 = mreset(5);
    chk("mid_rst_count", 32'(bus.Chip_Count), 32'h0);
    chk("mid_rst_a", 32'(dut.u_lfsr_a.State), 32'h3FF);
    chk("mid_rst_b", 32'(dut.u_lfsr_b.State), 32'h3FF);
    run_def(40);

`ifdef GOLD_PHASE_TAP_EN
    // Out-of-range select clamps to LEN-1; equal selects cancel.
    psel0 = 12; bus.Phase_Sel_0 = 4'(psel0);
    #1 chk("clamp_chip", 32'(bus.Chip), 32'(md.a[9] ^ md.b[9] ^ md.b[5]));
    psel0 = 5; bus.Phase_Sel_0 = 4'(psel0);
    #1 chk("cancel_chip", 32'(bus.Chip), 32'(md.a[9]));
    psel0 = 1; bus.Phase_Sel_0 = 4'(psel0);
`endif

    // Short-epoch instance gets non-trivial held seeds so wrap reload is visible.
    bus7.Load_En = 1'b1; bus7.Seed_A = 5'h0A; bus7.Seed_B = 5'h13;
    tick();
    bus7.Load_En = 1'b0;
    m7 = mload(m7, 32'h0A, 32'h13);
    chk("l7_chip", 32'(bus7.Chip), 32'(mchip(m7.a, m7.b, 5)));

    ep_seen = 0;
    for (int unsigned i = 0; i < 70; i++) begin
      bus5.Enable = 1'b1; bus7.Enable = 1'b1;
      tick();
      m5 = mstep(m5, 5, 32'h12, 32'h1E, 31);
      m7 = mstep(m7, 5, 32'h12, 32'h1E, 7);
      chk("l5_chip", 32'(bus5.Chip), 32'(mchip(m5.a, m5.b, 5)));
      chk("l5_count", 32'(bus5.Chip_Count), m5.cnt);
      chk("l5_epoch", 32'(bus5.Epoch), 32'(m5.ep));
      chk("l7_chip", 32'(bus7.Chip), 32'(mchip(m7.a, m7.b, 5)));
      chk("l7_count", 32'(bus7.Chip_Count), m7.cnt);
      chk("l7_epoch", 32'(bus7.Epoch), 32'(m7.ep));
      if (bus5.Epoch) ep_seen++;
    end
    bus5.Enable = 1'b0; bus7.Enable = 1'b0;
    chk("l5_epoch_total", ep_seen, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
